comb_differentiator: RTL and testbench

//   Decimating comb (differentiator) stage, the counterpart of the running integrator in the filter chain.

---
 rtl/comb_differentiator.sv | 107 ++++++++++
 tb/tb_comb_differentiator.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/comb_differentiator.sv
// Decimating comb stage of the CIC chain: keeps every DECIM_FACTOR-th accepted
// sample and emits the saturated difference against the sample DIFF_DELAY kept samples back.
module comb_differentiator #(
    parameter int DATA_WIDTH   = 16,
    parameter int DIFF_DELAY   = 2,
    parameter int DECIM_FACTOR = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic                         in_valid,
    input  logic signed [DATA_WIDTH-1:0] in,
    output logic signed [DATA_WIDTH-1:0] out,
    output logic                         out_valid,
    output logic                         primed,
    output logic                         sat
);

    localparam int PHASE_W = (DECIM_FACTOR > 1) ? $clog2(DECIM_FACTOR) : 1;
    localparam int PRIME_W = $clog2(DIFF_DELAY + 1);

    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(DECIM_FACTOR - 1);
    localparam logic [PRIME_W-1:0] PRIME_FULL = PRIME_W'(DIFF_DELAY);

    localparam logic signed [DATA_WIDTH-1:0] MAX_VAL = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] MIN_VAL = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    // The W+1-bit difference overflows W bits exactly when its top two bits disagree.
    function automatic logic is_clipped(input logic signed [DATA_WIDTH:0] v);
        return v[DATA_WIDTH] != v[DATA_WIDTH-1];
    endfunction

    function automatic logic signed [DATA_WIDTH-1:0] saturate(input logic signed [DATA_WIDTH:0] v);
        if (v[DATA_WIDTH] != v[DATA_WIDTH-1]) begin
            return v[DATA_WIDTH] ? MIN_VAL : MAX_VAL;
        end
        return v[DATA_WIDTH-1:0];
    endfunction

    logic [PHASE_W-1:0]            phase_q, phase_d;
    logic [PRIME_W-1:0]            prime_q, prime_d;
    logic signed [DATA_WIDTH-1:0]  dly_q [DIFF_DELAY];
    logic signed [DATA_WIDTH-1:0]  dly_d [DIFF_DELAY];
    logic signed [DATA_WIDTH-1:0]  out_q, out_d;
    logic                          out_valid_q, out_valid_d;
    logic                          sat_q, sat_d;

    logic                          accept;
    logic                          keep;
    logic signed [DATA_WIDTH:0]    diff;

    always_comb begin
        accept      = en & in_valid;
        keep        = accept && (phase_q == PHASE_LAST);
        diff        = {in[DATA_WIDTH-1], in}
                    - {dly_q[DIFF_DELAY-1][DATA_WIDTH-1], dly_q[DIFF_DELAY-1]};
        phase_d     = phase_q;
        prime_d     = prime_q;
        dly_d       = dly_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        sat_d       = 1'b0;

        if (accept) begin
            phase_d = keep ? '0 : phase_q + PHASE_W'(1);
        end

        if (keep) begin
            dly_d[0] = in;
            for (int i = 1; i < DIFF_DELAY; i++) begin
                dly_d[i] = dly_q[i-1];
            end
            out_d       = saturate(diff);
            out_valid_d = 1'b1;
            sat_d       = is_clipped(diff);
            if (prime_q != PRIME_FULL) begin
                prime_d = prime_q + PRIME_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_q     <= '0;
            prime_q     <= '0;
            for (int i = 0; i < DIFF_DELAY; i++) begin
                dly_q[i] <= '0;
            end
            out_q       <= '0;
            out_valid_q <= 1'b0;
            sat_q       <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            prime_q     <= prime_d;
            dly_q       <= dly_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            sat_q       <= sat_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign sat       = sat_q;
    assign primed    = (prime_q == PRIME_FULL);

endmodule

// File: tb/tb_comb_differentiator.sv
// Scoreboard bench for comb_differentiator across several M/R configurations.
module tb_comb_differentiator;

    typedef struct packed {
        logic signed [15:0] v;
        logic               s;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    // a: M=2,R=1   b: M=1,R=3   c: M=1,R=1   d: M=1,R=2
    logic a_en, a_vld, a_ov, a_pr, a_sat;
    logic b_en, b_vld, b_ov, b_pr, b_sat;
    logic c_en, c_vld, c_ov, c_pr, c_sat;
    logic d_en, d_vld, d_ov, d_pr, d_sat;
    logic signed [15:0] a_in, a_out, b_in, b_out, c_in, c_out, d_in, d_out;

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];
    exp_t qd[$];

    comb_differentiator #(.DATA_WIDTH(16), .DIFF_DELAY(2), .DECIM_FACTOR(1)) u_a (
        .clk(clk), .rst_n(rst_n), .en(a_en), .in_valid(a_vld), .in(a_in),
        .out(a_out), .out_valid(a_ov), .primed(a_pr), .sat(a_sat));
    comb_differentiator #(.DATA_WIDTH(16), .DIFF_DELAY(1), .DECIM_FACTOR(3)) u_b (
        .clk(clk), .rst_n(rst_n), .en(b_en), .in_valid(b_vld), .in(b_in),
        .out(b_out), .out_valid(b_ov), .primed(b_pr), .sat(b_sat));
    comb_differentiator #(.DATA_WIDTH(16), .DIFF_DELAY(1), .DECIM_FACTOR(1)) u_c (
        .clk(clk), .rst_n(rst_n), .en(c_en), .in_valid(c_vld), .in(c_in),
        .out(c_out), .out_valid(c_ov), .primed(c_pr), .sat(c_sat));
    comb_differentiator #(.DATA_WIDTH(16), .DIFF_DELAY(1), .DECIM_FACTOR(2)) u_d (
        .clk(clk), .rst_n(rst_n), .en(d_en), .in_valid(d_vld), .in(d_in),
        .out(d_out), .out_valid(d_ov), .primed(d_pr), .sat(d_sat));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        exp_t e;
        rst_n = 1'b0;
        a_en = 1'b1; a_vld = 1'b1; a_in = 16'sd1234;
        tick();
        tick();
        chk_cnt++;
        if ({a_out, a_ov, a_pr, a_sat} !== 19'd0)
            $display("FAIL reset_a got out=%0d ov=%b pr=%b sat=%b want all 0", a_out, a_ov, a_pr, a_sat);
        else pass_cnt++;
        chk_cnt++;
        if ({b_out, b_ov, b_pr, c_out, c_ov, d_out, d_ov, d_pr} !== 38'd0)
            $display("FAIL reset_bcd got b=%0d/%b c=%0d/%b d=%0d/%b want 0", b_out, b_ov, c_out, c_ov, d_out, d_ov);
        else pass_cnt++;
        a_vld = 1'b0;
        rst_n = 1'b1;
        tick();
        chk_cnt++;
        if (a_ov !== 1'b0 || a_out !== 16'sd0)
            $display("FAIL reset_release got ov=%b out=%0d want 0 0", a_ov, a_out);
        else pass_cnt++;
        e = '0;
        qa.delete();
    endtask

    task automatic test_back_to_back();
        logic signed [15:0] ins  [4];
        logic signed [15:0] outs [4];
        exp_t e;
        ins  = '{16'sd100, 16'sd300, 16'sd600, 16'sd1000};
        outs = '{16'sd100, 16'sd300, 16'sd500, 16'sd700};
        for (int i = 0; i < 4; i++) begin
            a_en = 1'b1; a_vld = 1'b1; a_in = ins[i];
            qa.push_back('{v: outs[i], s: 1'b0});
            tick();
            chk_cnt++;
            if (a_ov !== 1'b1) $display("FAIL b2b_valid[%0d] got %b want 1", i, a_ov);
            else pass_cnt++;
            if (a_ov === 1'b1) begin
                chk_cnt++;
                if (qa.size() == 0) $display("FAIL b2b_unexpected[%0d] got out=%0d want none", i, a_out);
                else begin
                    e = qa.pop_front();
                    if (a_out !== e.v || a_sat !== e.s)
                        $display("FAIL b2b_out[%0d] got %0d/%b want %0d/%b", i, a_out, a_sat, e.v, e.s);
                    else pass_cnt++;
                end
            end
            chk_cnt++;
            if (a_pr !== (i >= 1)) $display("FAIL b2b_primed[%0d] got %b want %b", i, a_pr, (i >= 1));
            else pass_cnt++;
        end
        a_vld = 1'b0;
        tick();
        chk_cnt++;
        if (a_ov !== 1'b0 || a_out !== 16'sd700 || qa.size() != 0)
            $display("FAIL b2b_idle got ov=%b out=%0d pend=%0d want 0 700 0", a_ov, a_out, qa.size());
        else pass_cnt++;
    endtask

    task automatic test_saturation();
        logic signed [15:0] ins  [6];
        exp_t               exps [6];
        exp_t e;
        ins  = '{-16'sd32768, 16'sd0, 16'sd32767, 16'sd32767, 16'sd0, -16'sd32768};
        exps = '{'{v: -16'sd32768, s: 1'b0}, '{v: 16'sd0, s: 1'b0}, '{v: 16'sd32767, s: 1'b1},
                 '{v: 16'sd32767, s: 1'b0}, '{v: -16'sd32767, s: 1'b0}, '{v: -16'sd32768, s: 1'b1}};
        pulse_reset();
        for (int i = 0; i < 6; i++) begin
            a_en = 1'b1; a_vld = 1'b1; a_in = ins[i];
            qa.push_back(exps[i]);
            tick();
            chk_cnt++;
            if (a_ov !== 1'b1) $display("FAIL sat_valid[%0d] got %b want 1", i, a_ov);
            else pass_cnt++;
            if (a_ov === 1'b1) begin
                chk_cnt++;
                if (qa.size() == 0) $display("FAIL sat_unexpected[%0d] got out=%0d want none", i, a_out);
                else begin
                    e = qa.pop_front();
                    if (a_out !== e.v || a_sat !== e.s)
                        $display("FAIL sat_out[%0d] got %0d/%b want %0d/%b", i, a_out, a_sat, e.v, e.s);
                    else pass_cnt++;
                end
            end
        end
        a_vld = 1'b0;
        tick();
        chk_cnt++;
        if (a_sat !== 1'b0 || a_ov !== 1'b0 || qa.size() != 0)
            $display("FAIL sat_idle got sat=%b ov=%b pend=%0d want 0 0 0", a_sat, a_ov, qa.size());
        else pass_cnt++;
    endtask

    task automatic test_decimation();
        exp_t e;
        int   n_out;
        n_out = 0;
        for (int i = 1; i <= 9; i++) begin
            b_en = 1'b1; b_vld = 1'b1; b_in = 16'(i);
            if (i % 3 == 0) qb.push_back('{v: 16'sd3, s: 1'b0});
            tick();
            chk_cnt++;
            if (b_ov !== (i % 3 == 0)) $display("FAIL dec_valid[%0d] got %b want %b", i, b_ov, (i % 3 == 0));
            else pass_cnt++;
            if (b_ov === 1'b1) begin
                n_out++;
                chk_cnt++;
                if (qb.size() == 0) $display("FAIL dec_unexpected[%0d] got out=%0d want none", i, b_out);
                else begin
                    e = qb.pop_front();
                    if (b_out !== e.v || b_sat !== e.s)
                        $display("FAIL dec_out[%0d] got %0d/%b want %0d/%b", i, b_out, b_sat, e.v, e.s);
                    else pass_cnt++;
                end
            end
        end
        b_vld = 1'b0;
        tick();
        chk_cnt++;
        if (n_out != 3 || qb.size() != 0 || b_pr !== 1'b1)
            $display("FAIL dec_count got outs=%0d pend=%0d pr=%b want 3 0 1", n_out, qb.size(), b_pr);
        else pass_cnt++;
    endtask

    task automatic test_gating();
        logic               ens  [3];
        logic signed [15:0] ins  [3];
        exp_t e;
        ens = '{1'b1, 1'b0, 1'b1};
        ins = '{16'sd10, 16'sd20, 16'sd30};
        for (int i = 0; i < 3; i++) begin
            c_en = ens[i]; c_vld = 1'b1; c_in = ins[i];
            if (ens[i]) qc.push_back('{v: (i == 0) ? 16'sd10 : 16'sd20, s: 1'b0});
            tick();
            chk_cnt++;
            if (c_ov !== ens[i]) $display("FAIL gate_valid[%0d] got %b want %b", i, c_ov, ens[i]);
            else pass_cnt++;
            if (c_ov === 1'b1) begin
                chk_cnt++;
                if (qc.size() == 0) $display("FAIL gate_unexpected[%0d] got out=%0d want none", i, c_out);
                else begin
                    e = qc.pop_front();
                    if (c_out !== e.v || c_sat !== e.s)
                        $display("FAIL gate_out[%0d] got %0d/%b want %0d/%b", i, c_out, c_sat, e.v, e.s);
                    else pass_cnt++;
                end
            end else begin
                chk_cnt++;
                if (c_out !== 16'sd10) $display("FAIL gate_hold got %0d want 10", c_out);
                else pass_cnt++;
            end
        end
        c_vld = 1'b0;
    endtask

    task automatic test_phase_hold();
        logic vlds [4];
        exp_t e;
        int   n_out;
        vlds  = '{1'b1, 1'b0, 1'b1, 1'b0};
        n_out = 0;
        for (int i = 0; i < 4; i++) begin
            d_en = 1'b1; d_vld = vlds[i]; d_in = (i < 2) ? 16'sd5 : 16'sd7;
            if (i == 2) qd.push_back('{v: 16'sd7, s: 1'b0});
            tick();
            chk_cnt++;
            if (d_ov !== (i == 2)) $display("FAIL phase_valid[%0d] got %b want %b", i, d_ov, (i == 2));
            else pass_cnt++;
            if (d_ov === 1'b1) begin
                n_out++;
                chk_cnt++;
                if (qd.size() == 0) $display("FAIL phase_unexpected[%0d] got out=%0d want none", i, d_out);
                else begin
                    e = qd.pop_front();
                    if (d_out !== e.v || d_sat !== e.s)
                        $display("FAIL phase_out[%0d] got %0d/%b want %0d/%b", i, d_out, d_sat, e.v, e.s);
                    else pass_cnt++;
                end
            end
        end
        // Half a phase, then a frozen cycle with en=0, then completion.
        d_vld = 1'b1; d_in = 16'sd100;
        tick();
        d_en = 1'b0; d_in = 16'sd999;
        tick();
        chk_cnt++;
        if (d_ov !== 1'b0) $display("FAIL phase_frozen got ov=%b want 0", d_ov);
        else pass_cnt++;
        d_en = 1'b1; d_in = 16'sd12;
        qd.push_back('{v: 16'sd5, s: 1'b0});
        tick();
        chk_cnt++;
        if (d_ov !== 1'b1 || qd.size() == 0) $display("FAIL phase_resume got ov=%b want 1", d_ov);
        else begin
            e = qd.pop_front();
            if (d_out !== e.v) $display("FAIL phase_resume_out got %0d want %0d", d_out, e.v);
            else pass_cnt++;
        end
        d_vld = 1'b0;
        chk_cnt++;
        if (n_out != 1 || qd.size() != 0) $display("FAIL phase_count got %0d pend=%0d want 1 0", n_out, qd.size());
        else pass_cnt++;
    endtask

    task automatic test_reset_midstream();
        logic signed [15:0] ins [2];
        exp_t e;
        ins = '{16'sd50, 16'sd60};
        pulse_reset();
        for (int i = 0; i < 2; i++) begin
            a_en = 1'b1; a_vld = 1'b1; a_in = ins[i];
            qa.push_back('{v: ins[i], s: 1'b0});
            tick();
            chk_cnt++;
            if (a_ov !== 1'b1 || qa.size() == 0) $display("FAIL rst_pre_valid[%0d] got %b want 1", i, a_ov);
            else begin
                e = qa.pop_front();
                if (a_out !== e.v) $display("FAIL rst_pre_out[%0d] got %0d want %0d", i, a_out, e.v);
                else pass_cnt++;
            end
        end
        rst_n = 1'b0; a_in = 16'sd999;
        tick();
        chk_cnt++;
        if ({a_out, a_ov, a_pr, a_sat} !== 19'd0)
            $display("FAIL rst_mid got out=%0d ov=%b pr=%b sat=%b want all 0", a_out, a_ov, a_pr, a_sat);
        else pass_cnt++;
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            a_in = (i == 0) ? 16'sd70 : 16'sd80;
            qa.push_back('{v: a_in, s: 1'b0});
            tick();
            chk_cnt++;
            if (a_ov !== 1'b1 || qa.size() == 0) $display("FAIL rst_post_valid[%0d] got %b want 1", i, a_ov);
            else begin
                e = qa.pop_front();
                if (a_out !== e.v) $display("FAIL rst_post_out[%0d] got %0d want %0d", i, a_out, e.v);
                else pass_cnt++;
            end
            chk_cnt++;
            if (a_pr !== (i == 1)) $display("FAIL rst_post_primed[%0d] got %b want %b", i, a_pr, (i == 1));
            else pass_cnt++;
        end
        a_vld = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        a_en = 1'b0; a_vld = 1'b0; a_in = '0;
        b_en = 1'b0; b_vld = 1'b0; b_in = '0;
        c_en = 1'b0; c_vld = 1'b0; c_in = '0;
        d_en = 1'b0; d_vld = 1'b0; d_in = '0;
        test_reset();
        test_back_to_back();
        test_saturation();
        test_decimation();
        test_gating();
        test_phase_hold();
        test_reset_midstream();
        tick();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
